tpu_result_serializer: RTL and testbench

Read-out counterpart of the byte-wide weight/input loader: it captures the four 16-bit results of the 2x2 systolic multiply and streams them out one byte per handshake on an 8-bit output bus. It sits between the systolic array outputs and the top-level output pins. The host drains one complete result set per `load` request.

---
 rtl/tpu_result_serializer.sv | 117 +++++++++++
 tb/tb_tpu_result_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_serializer.sv
// Captures the four 16-bit systolic-array results and streams them out one byte per handshake.
// Optional build macro TPU_OUT_SAT8_EN: saturate each result to signed 8 bits and send 4 bytes instead of 8.
module tpu_result_serializer (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic signed [15:0] results [0:3],
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [2:0]         byte_idx
);

`ifdef TPU_OUT_SAT8_EN
    localparam int NB = 4;
`else
    localparam int NB = 8;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NB - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t             state, state_next;
    logic [7:0]         data_next;
    logic [2:0]         idx_next;
    logic               capture;
    logic signed [15:0] shadow [0:3];

`ifdef TPU_OUT_SAT8_EN
    function automatic logic [7:0] byte_at(input logic signed [15:0] r [0:3],
                                           input logic [2:0] idx);
        logic signed [15:0] v;
        v = r[idx[1:0]];
        // Upper nine bits all equal means the value already fits in a signed byte.
        if (v[15:7] == 9'h000 || v[15:7] == 9'h1FF)
            return v[7:0];
        else if (v[15])
            return 8'h80;
        else
            return 8'h7F;
    endfunction
`else
    function automatic logic [7:0] byte_at(input logic signed [15:0] r [0:3],
                                           input logic [2:0] idx);
        logic signed [15:0] v;
        v = r[idx[2:1]];
        return idx[0] ? v[15:8] : v[7:0];
    endfunction
`endif

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        idx_next   = byte_idx;
        data_next  = out_data;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                idx_next  = 3'd0;
                data_next = 8'h00;
                if (load) begin
                    capture    = 1'b1;
                    state_next = SEND;
                    // Shadow is not written yet, so byte 0 comes straight from the inputs.
                    data_next  = byte_at(results, 3'd0);
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (byte_idx == LAST_IDX) begin
                        state_next = DONE;
                        idx_next   = 3'd0;
                        data_next  = 8'h00;
                    end else begin
                        idx_next  = byte_idx + 3'd1;
                        data_next = byte_at(shadow, byte_idx + 3'd1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                data_next  = 8'h00;
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                data_next  = 8'h00;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out_data <= 8'h00;
            byte_idx <= 3'd0;
            // NOTE: the shadow array is reset too, so an aborted set leaves no stale result behind.
            shadow   <= '{default: '0};
        end else begin
            state    <= state_next;
            out_data <= data_next;
            byte_idx <= idx_next;
            if (capture)
                shadow <= results;
        end
    end

    // Flags decode state only, keeping out_ready off any path to out_valid.
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_tpu_result_serializer.sv
// Table-driven bench for tpu_result_serializer; honours TPU_OUT_SAT8_EN the same way as the design.
module tb_tpu_result_serializer;

`ifdef TPU_OUT_SAT8_EN
    localparam int NB      = 4;
    localparam int RST_IDX = 2;
`else
    localparam int NB      = 8;
    localparam int RST_IDX = 4;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               load;
    logic signed [15:0] results [0:3];
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [2:0]         byte_idx;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       load;
        logic       ready;
        logic [7:0] data;
        logic [2:0] idx;
        logic       valid;
        logic       busy;
        logic       done;
        logic       chk_dat;
    } vec_t;

    vec_t vq[$];

    logic [7:0] exp_main [0:7];
    logic [7:0] exp_55   [0:7];
`ifdef TPU_OUT_SAT8_EN
    logic [7:0] exp_bnd  [0:7];
`endif

    tpu_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .results   (results),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .byte_idx  (byte_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 8'(out_valid), 8'h00);
        check({tag, " busy"},  8'(busy),      8'h00);
        check({tag, " done"},  8'(done),      8'h00);
        check({tag, " data"},  out_data,      8'h00);
        check({tag, " idx"},   8'(byte_idx),  8'h00);
    endtask

    function automatic vec_t mk(input logic ld, input logic rdy, input logic [7:0] d,
                                input logic [2:0] i, input logic v, input logic b,
                                input logic dn, input logic cd);
        vec_t r;
        r.load = ld; r.ready = rdy; r.data = d; r.idx = i;
        r.valid = v; r.busy = b; r.done = dn; r.chk_dat = cd;
        return r;
    endfunction

    // One full transfer: load, NB bytes (optional stall after showing byte stall_at), done, idle.
    task automatic add_stream(input logic [7:0] b [0:7], input int stall_at,
                              input int stall_len, input logic hold);
        vq.push_back(mk(1'b1, 1'b1, b[0], 3'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        for (int k = 1; k < NB; k++) begin
            if (k - 1 == stall_at)
                for (int s = 0; s < stall_len; s++)
                    vq.push_back(mk(hold, 1'b0, b[k-1], 3'(k-1), 1'b1, 1'b1, 1'b0, 1'b1));
            vq.push_back(mk(hold, 1'b1, b[k], 3'(k), 1'b1, 1'b1, 1'b0, 1'b1));
        end
        vq.push_back(mk(hold, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk(hold, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            load      = vq[i].load;
            out_ready = vq[i].ready;
            step();
            check($sformatf("%s[%0d] valid", tag, i), 8'(out_valid), 8'(vq[i].valid));
            check($sformatf("%s[%0d] busy", tag, i),  8'(busy),      8'(vq[i].busy));
            check($sformatf("%s[%0d] done", tag, i),  8'(done),      8'(vq[i].done));
            if (vq[i].chk_dat) begin
                check($sformatf("%s[%0d] data", tag, i), out_data,     vq[i].data);
                check($sformatf("%s[%0d] idx", tag, i),  8'(byte_idx), 8'(vq[i].idx));
            end
        end
        vq.delete();
        load = 1'b0;
    endtask

    task automatic set_main();
        results[0] = 16'h1234; results[1] = 16'hABCD;
        results[2] = 16'h0001; results[3] = 16'hFFFF;
    endtask

    initial begin
`ifdef TPU_OUT_SAT8_EN
        exp_main = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_55   = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_bnd  = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        exp_main = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
        exp_55   = '{default: 8'h55};
`endif
        rst = 1'b1; load = 1'b0; out_ready = 1'b0;
        set_main();
        step(); step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("idle");

        // Basic stream with out_ready held high.
        add_stream(exp_main, -1, 0, 1'b0);
        run_table("basic");

        // Three-cycle stall while byte 2 is presented.
        add_stream(exp_main, 2, 3, 1'b0);
        run_table("stall");

        // Input change plus load pulse during SEND must not disturb the stream.
        load = 1'b1; out_ready = 1'b1;
        step();
        check("ign b0", out_data, exp_main[0]);
        results = '{default: 16'h5555};
        for (int k = 1; k < NB; k++) begin
            load = (k == 1);
            step();
            check($sformatf("ign b%0d", k), out_data, exp_main[k]);
            check($sformatf("ign i%0d", k), 8'(byte_idx), 8'(k));
        end
        load = 1'b1;
        step();
        check("ign done", 8'(done), 8'h01);
        load = 1'b0;
        step();
        check_idle("ign idle");
        add_stream(exp_55, -1, 0, 1'b0);
        run_table("five5");

        // Reset mid-transfer aborts with no done pulse.
        set_main();
        load = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= RST_IDX; k++) step();
        check("pre-rst idx", 8'(byte_idx), 8'(RST_IDX));
        rst = 1'b1;
        step();
        check_idle("abort");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("abort nodone%0d", k), 8'(done), 8'h00);
            check($sformatf("abort nvalid%0d", k), 8'(out_valid), 8'h00);
        end
        add_stream(exp_main, -1, 0, 1'b0);
        run_table("restart");

        // Load held high: back-to-back transfers every NB+2 cycles.
        for (int t = 0; t < 3; t++) add_stream(exp_main, -1, 0, 1'b1);
        run_table("hold");
        step();
        check("hold end busy", 8'(busy), 8'h00);

`ifdef TPU_OUT_SAT8_EN
        // Saturation boundaries: 127, 128, -128, -129.
        results[0] = 16'h007F; results[1] = 16'h0080;
        results[2] = 16'hFF80; results[3] = 16'hFF7F;
        add_stream(exp_bnd, -1, 0, 1'b0);
        run_table("sat");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
